// File: rtl/progmem_loader_pkg.sv
// rtl/progmem_loader_pkg.sv - shared types and constants for the program-memory loader
//
// Purpose: the loader frame-state enum, the stream byte width, and the default
// instruction/address widths. The defaults are also used by the CPU's program memory.
package progmem_loader_pkg;

  localparam int FRAME_W         = 8;
  localparam int DEFAULT_INSTR_W = 16;
  localparam int DEFAULT_ADDR_W  = 10;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHECK,
    RUN,
    ERR
  } loader_state_e;

endpackage

// File: rtl/loader_frame_fsm.sv
// rtl/loader_frame_fsm.sv - frame parser: state, word counter, byte assembly
//
// Purpose: parses the frame {N_hi, N_lo, (hi, lo) x N [, checksum]}.
// It raises a one-cycle combinational write request in the cycle the low byte
// of each word transfers. The top registers that request onto the program-memory port.
// Optional: LOADER_CHECKSUM_EN adds the trailing XOR checksum byte (state CHECK).
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_valid, in_data    - byte stream from the source
//   in_ready             - decoded from the registered state only
//   state                - current frame state (registered)
//   wr_en/wr_addr/wr_data - write request, valid in the DATA_LO transfer cycle
module loader_frame_fsm
  import progmem_loader_pkg::*;
#(
  parameter int INSTR_W = DEFAULT_INSTR_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [FRAME_W-1:0]  in_data,
  output logic                in_ready,
  output loader_state_e       state,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [INSTR_W-1:0]  wr_data
);

  localparam int CNT_W = ADDR_W + 1;
  // Largest legal word count; 17 bits so that a full 2^16-word space would still compare.
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e AFTER_DATA = CHECK;
`else
  localparam loader_state_e AFTER_DATA = RUN;
`endif

  loader_state_e      state_q, state_d;
  logic [7:0]         len_hi_q, len_hi_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         hi_q, hi_d;
  logic               xfer;
  logic [15:0]        n_full;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CHECK:                            in_ready = 1'b1;
`endif
      default:                          in_ready = 1'b0;
    endcase
  end

  always_comb begin
    xfer     = in_valid && in_ready;
    n_full   = {len_hi_q, in_data};
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    wr_en    = 1'b0;
    wr_addr  = cnt_q[ADDR_W-1:0];
    wr_data  = INSTR_W'({hi_q, in_data});
`ifdef LOADER_CHECKSUM_EN
    // Running XOR of every frame byte; the CHECK byte itself is compared, not folded in.
    csum_d   = xfer ? (csum_q ^ in_data) : csum_q;
`endif
    case (state_q)
      LEN_HI: if (xfer) begin
        len_hi_d = in_data;
        state_d  = LEN_LO;
      end
      LEN_LO: if (xfer) begin
        // Only the low CNT_W bits are kept; any count that needs more is rejected.
        len_d = n_full[CNT_W-1:0];
        if (n_full == 16'd0)
          state_d = AFTER_DATA;
        else if ({1'b0, n_full} > MAX_N)
          state_d = ERR;
        else
          state_d = DATA_HI;
      end
      DATA_HI: if (xfer) begin
        hi_d    = in_data;
        state_d = DATA_LO;
      end
      DATA_LO: if (xfer) begin
        wr_en   = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_d == len_q) ? AFTER_DATA : DATA_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (xfer) begin
        state_d = (in_data == csum_q) ? RUN : ERR;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LEN_HI;
      len_hi_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign state = state_q;

endmodule

// File: rtl/progmem_loader.sv
// rtl/progmem_loader.sv - boot-time program-memory writer that holds the CPU in reset
//
// Purpose: takes a byte stream and writes 16-bit words to program memory from address 0.
// It releases cpu_reset one cycle after the final write.
// Optional: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   in_valid, in_data, in_ready - byte stream handshake
//   pm_we, pm_addr, pm_wdata   - program-memory write port (one-cycle pulses)
//   cpu_reset                  - high during reset, load and error
//   done                       - load complete, CPU running
//   err                        - frame rejected
module progmem_loader
  import progmem_loader_pkg::*;
#(
  parameter int INSTR_W = DEFAULT_INSTR_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               pm_we,
  output logic [ADDR_W-1:0]  pm_addr,
  output logic [INSTR_W-1:0] pm_wdata,
  output logic               cpu_reset,
  output logic               done,
  output logic               err
);

  loader_state_e      state;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [INSTR_W-1:0] wr_data;

  logic               pm_we_q, pm_we_d;
  logic [ADDR_W-1:0]  pm_addr_q, pm_addr_d;
  logic [INSTR_W-1:0] pm_wdata_q, pm_wdata_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  loader_frame_fsm #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W)
  ) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .state    (state),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  // Status flags are registered from the state, which puts the cpu_reset fall
  // one cycle after the last pm_we pulse, when memory is already stable.
  always_comb begin
    pm_we_d     = wr_en;
    pm_addr_d   = wr_en ? wr_addr : pm_addr_q;
    pm_wdata_d  = wr_en ? wr_data : pm_wdata_q;
    cpu_reset_d = (state != RUN);
    done_d      = (state == RUN);
    err_d       = (state == ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pm_we_q     <= 1'b0;
      pm_addr_q   <= '0;
      pm_wdata_q  <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pm_we_q     <= pm_we_d;
      pm_addr_q   <= pm_addr_d;
      pm_wdata_q  <= pm_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign pm_we     = pm_we_q;
  assign pm_addr   = pm_addr_q;
  assign pm_wdata  = pm_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
